// File: rtl/gray_conv_arb_pkg.sv
// Shared types and helpers for the round-robin Gray-to-binary arbiter.
// Holds the FSM state encodings and a clog2 used to validate ID_W.
package gray_conv_arb_pkg;

  // 2'd3 is unreachable and is decoded as IDLE by the FSM default branch
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gray_conv_arb_if.sv
// Requester-side bus of the shared Gray converter: requests, flattened Gray
// inputs, per-requester acks and the tagged binary result.
interface gray_conv_arb_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int CNT_W = 16,
  parameter int ID_W  = 2
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] gray_in;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      bin_out;
  logic                  bin_vld;
  logic [ID_W-1:0]       bin_id;
  logic                  busy;
  logic [CNT_W-1:0]      conv_cnt;

  modport master (
    output req, gray_in,
    input  ack, bin_out, bin_vld, bin_id, busy, conv_cnt
  );

  modport slave (
    input  req, gray_in,
    output ack, bin_out, bin_vld, bin_id, busy, conv_cnt
  );

endinterface

// File: rtl/gray_conv_arb_gray2bin.sv
// Purely combinational Gray-to-binary converter: bit i is the XOR of all
// Gray bits from the MSB down to i.
module gray2bin_comb #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign bin[gi] = ^gray[WIDTH-1:gi];
    end
  endgenerate

endmodule

// File: rtl/gray_conv_arb.sv
// Round-robin arbiter sharing one registered Gray-to-binary stage among NREQ
// requesters; one conversion every three cycles, result tagged with the ID.
module gray_conv_arb
  import gray_conv_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int CNT_W = 16,
  parameter int ID_W  = 2
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  gray_conv_arb_if.slave bus
);

  state_t            state, state_next;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_next;
  logic [WIDTH-1:0]  gray_q, gray_q_next;
  logic [ID_W-1:0]   id_q, id_q_next;
  logic [WIDTH-1:0]  bin_q, bin_q_next;
  logic [WIDTH-1:0]  bin_conv;

  logic [NREQ-1:0]   ack_reg, ack_next, ack_dec;
  logic [WIDTH-1:0]  bin_out_reg, bin_out_next;
  logic              bin_vld_reg, bin_vld_next;
  logic [ID_W-1:0]   bin_id_reg, bin_id_next;
  logic              busy_reg, busy_next;
  logic [CNT_W-1:0]  conv_cnt_reg, conv_cnt_next;

  // Round robin: rotate so rr_ptr sits at bit 0, pick the lowest set bit,
  // then add rr_ptr back modulo NREQ.
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [ID_W-1:0]   off;
  logic [ID_W:0]     rr_sum;
  logic [ID_W-1:0]   winner, winner_inc;
  logic              any_req;

  assign req_dbl = {bus.req, bus.req};
  assign req_rot = req_dbl[rr_ptr +: NREQ];
  assign any_req = |bus.req;

  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        off = ID_W'(i);
      end
    end
  end

  assign rr_sum     = {1'b0, rr_ptr} + {1'b0, off};
  assign winner     = (rr_sum >= (ID_W+1)'(NREQ)) ? ID_W'(rr_sum - (ID_W+1)'(NREQ))
                                                  : rr_sum[ID_W-1:0];
  assign winner_inc = (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ack
      assign ack_dec[gi] = (id_q == ID_W'(gi));
    end
  endgenerate

  gray2bin_comb #(.WIDTH(WIDTH)) u_gray2bin (
    .gray (gray_q),
    .bin  (bin_conv)
  );

  always_comb begin
    state_next    = state;
    rr_ptr_next   = rr_ptr;
    gray_q_next   = gray_q;
    id_q_next     = id_q;
    bin_q_next    = bin_q;
    ack_next      = '0;
    bin_vld_next  = 1'b0;
    bin_out_next  = bin_out_reg;
    bin_id_next   = bin_id_reg;
    conv_cnt_next = conv_cnt_reg;
    case (state)
      ST_CONV: begin
        bin_q_next = bin_conv;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        ack_next      = ack_dec;
        bin_vld_next  = 1'b1;
        bin_out_next  = bin_q;
        bin_id_next   = id_q;
        conv_cnt_next = conv_cnt_reg + CNT_W'(1);
        state_next    = ST_IDLE;
      end
      default: begin
        if (any_req) begin
          gray_q_next = bus.gray_in[winner*WIDTH +: WIDTH];
          id_q_next   = winner;
          rr_ptr_next = winner_inc;
          state_next  = ST_CONV;
        end
      end
    endcase
    busy_next = (state_next == ST_CONV) || (state_next == ST_RESP);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      gray_q       <= '0;
      id_q         <= '0;
      bin_q        <= '0;
      ack_reg      <= '0;
      bin_out_reg  <= '0;
      bin_vld_reg  <= 1'b0;
      bin_id_reg   <= '0;
      busy_reg     <= 1'b0;
      conv_cnt_reg <= '0;
    end else begin
      state        <= state_next;
      rr_ptr       <= rr_ptr_next;
      gray_q       <= gray_q_next;
      id_q         <= id_q_next;
      bin_q        <= bin_q_next;
      ack_reg      <= ack_next;
      bin_out_reg  <= bin_out_next;
      bin_vld_reg  <= bin_vld_next;
      bin_id_reg   <= bin_id_next;
      busy_reg     <= busy_next;
      conv_cnt_reg <= conv_cnt_next;
    end
  end

  assign bus.ack      = ack_reg;
  assign bus.bin_out  = bin_out_reg;
  assign bus.bin_vld  = bin_vld_reg;
  assign bus.bin_id   = bin_id_reg;
  assign bus.busy     = busy_reg;
  assign bus.conv_cnt = conv_cnt_reg;

endmodule

// File: tb/tb_gray_conv_arb.sv
// Directed bench for gray_conv_arb: a 16-bit-counter instance and a 4-bit-counter
// instance share the same requester stimulus; results are hand-computed.
module tb_gray_conv_arb;
  import gray_conv_arb_pkg::*;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;

  generate
    if (ID_W != clog2(NREQ)) begin : g_idw_bad
      initial $fatal(1, "ID_W does not equal clog2(NREQ)");
    end
  endgenerate

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  gray_conv_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ), .CNT_W(16), .ID_W(ID_W)) bus ();
  gray_conv_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ), .CNT_W(4),  .ID_W(ID_W)) bus4 ();

  assign bus4.req     = bus.req;
  assign bus4.gray_in = bus.gray_in;

  gray_conv_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .CNT_W(16), .ID_W(ID_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  gray_conv_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .CNT_W(4), .ID_W(ID_W)) dut4 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus4)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp_v);
    end else begin
      n_pass++;
    end
  endtask

  task automatic set_gray(input int k, input logic [7:0] v);
    bus.gray_in[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"},     bus.ack,      '0);
    check({tag, "_bin_out"}, bus.bin_out,  '0);
    check({tag, "_bin_vld"}, bus.bin_vld,  '0);
    check({tag, "_bin_id"},  bus.bin_id,   '0);
    check({tag, "_busy"},    bus.busy,     '0);
    check({tag, "_cnt"},     bus.conv_cnt, '0);
    check({tag, "_cnt4"},    bus4.conv_cnt, '0);
    check({tag, "_rr_ptr"},  dut.rr_ptr,   '0);
  endtask

  task automatic do_reset();
    bus.req   = '0;
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check_reset_vals("reset");
    sys_rst_n = 1'b1;
    exp_cnt   = 0;
  endtask

  // Waits for the result strobe, checks it, then drops the served request
  // at that same negedge so it is not re-granted.
  task automatic expect_resp(input int id, input logic [7:0] val, input int lat);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge sys_clk);
      n++;
      if (bus.bin_vld) begin
        seen = 1'b1;
      end else begin
        check("wait_busy", bus.busy, 1);
        check("wait_ack",  bus.ack,  0);
      end
    end
    if (!seen) begin
      check("resp_timeout", 0, 1);
    end else begin
      exp_cnt++;
      $display("resp id=%0d bin=%02h cnt=%0d lat=%0d", bus.bin_id, bus.bin_out, bus.conv_cnt, n);
      check("latency", n, lat);
      check("ack",     bus.ack, 32'(1) << id);
      check("bin_out", bus.bin_out, val);
      check("bin_id",  bus.bin_id, id);
      check("busy_resp", bus.busy, 0);
      check("cnt",     bus.conv_cnt, exp_cnt[15:0]);
      check("cnt4",    bus4.conv_cnt, exp_cnt[3:0]);
    end
    bus.req[id] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req     = '0;
    bus.gray_in = '0;
    do_reset();

    // Single request from requester 0
    set_gray(0, 8'h0C); set_gray(1, 8'h80); set_gray(2, 8'hFF); set_gray(3, 8'h01);
    bus.req = 4'b0001;
    expect_resp(0, 8'h08, 3);

    // All four requesters: order 0,1,2,3
    do_reset();
    bus.req = 4'b1111;
    expect_resp(0, 8'h08, 3);
    expect_resp(1, 8'hFF, 3);
    expect_resp(2, 8'hAA, 3);
    expect_resp(3, 8'h01, 3);

    // Fairness: after 2 is served, 3 wins over 1
    bus.req = 4'b0100;
    expect_resp(2, 8'hAA, 3);
    bus.req = 4'b1010;
    expect_resp(3, 8'h01, 3);
    expect_resp(1, 8'hFF, 3);

    // Reset in the middle of a conversion
    bus.req = 4'b0001;
    @(negedge sys_clk);
    check("midconv_busy", bus.busy, 1);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check_reset_vals("midconv");
    sys_rst_n = 1'b1;
    exp_cnt   = 0;
    expect_resp(0, 8'h08, 3);

    // Request dropped and Gray input changed while converting
    bus.req = 4'b0100;
    @(negedge sys_clk);
    check("drop_busy", bus.busy, 1);
    bus.req = 4'b0000;
    set_gray(2, 8'h00);
    expect_resp(2, 8'hAA, 2);

    // Counter wrap on the 4-bit instance: 17 conversions
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_gray(0, 8'(i ^ (i >> 1)));
      bus.req = 4'b0001;
      expect_resp(0, 8'(i), 3);
    end
    check("wrap_cnt4", bus4.conv_cnt, 4'h1);
    check("wrap_cnt",  bus.conv_cnt, 16'd17);

    // Idle with no requests: nothing moves, result holds
    bus.req = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      check("idle_vld",  bus.bin_vld, 0);
      check("idle_ack",  bus.ack, 0);
      check("idle_busy", bus.busy, 0);
      check("idle_cnt",  bus.conv_cnt, 16'd17);
      check("idle_cnt4", bus4.conv_cnt, 4'h1);
      check("idle_hold", bus.bin_out, 8'h10);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
